// File: rtl/gfx_arb_pkg.sv
// Shared definitions for the graphics memory slot arbiter: requester ids,
// FSM states, default timeout and the one-hot ack helper.
package gfx_arb_pkg;

  typedef enum logic [1:0] {
    REQ_BG  = 2'd0,
    REQ_FG  = 2'd1,
    REQ_TX  = 2'd2,
    REQ_SPR = 2'd3
  } req_id_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 31;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] vec;
    vec = 4'b0001 << idx;
    return vec;
  endfunction

endpackage

// File: rtl/gfx_mem_slot_arbiter_if.sv
// Requester and memory-port bundle of the graphics slot arbiter.
// The arbiter uses the slave view; fetch engines plus memory controller drive the master view.
interface gfx_mem_slot_arbiter_if #(
  parameter int AW = 22,
  parameter int DW = 16
);

  logic [3:0]      req;
  logic [4*AW-1:0] addr;
  logic [3:0]      ack;
  logic [DW-1:0]   rdata;
  logic            mem_cs;
  logic [AW-1:0]   mem_addr;
  logic            mem_ok;
  logic [DW-1:0]   mem_data;

  modport slave (
    input  req, addr, mem_ok, mem_data,
    output ack, rdata, mem_cs, mem_addr
  );

  modport master (
    output req, addr, mem_ok, mem_data,
    input  ack, rdata, mem_cs, mem_addr
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: the first requesting index
// found scanning ptr, ptr+1, ... (mod 4) wins.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] idx0_s;
  logic [1:0] idx1_s;
  logic [1:0] idx2_s;
  logic [1:0] idx3_s;

  assign idx0_s = ptr;
  assign idx1_s = ptr + 2'd1;
  assign idx2_s = ptr + 2'd2;
  assign idx3_s = ptr + 2'd3;

  // priority scan starting at the pointer, wrapping naturally in 2 bits
  always_comb begin
    grant = ptr;
    valid = |req;
    if (req[idx0_s]) begin
      grant = idx0_s;
    end else if (req[idx1_s]) begin
      grant = idx1_s;
    end else if (req[idx2_s]) begin
      grant = idx2_s;
    end else if (req[idx3_s]) begin
      grant = idx3_s;
    end else begin
      grant = ptr;
    end
  end

endmodule

// File: rtl/gfx_mem_slot_arbiter.sv
// Shares one graphics ROM/SDRAM read port between BG, FG, text and sprite
// fetchers using fixed pixel slots in the active area and round-robin in blanking.
module gfx_mem_slot_arbiter
  import gfx_arb_pkg::*;
#(
  parameter int AW      = 22,
  parameter int DW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_pix_en,
  input  logic [8:0]            hc,
  input  logic [8:0]            vc,
  input  logic                  hbl,
  input  logic                  vbl,
  gfx_mem_slot_arbiter_if.slave bus,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state_r;
  arb_state_e    state_nxt_s;
  logic [1:0]    owner_r;
  logic [1:0]    owner_nxt_s;
  logic [1:0]    rr_ptr_r;
  logic [1:0]    rr_ptr_nxt_s;
  logic [CW-1:0] wait_cnt_r;
  logic [CW-1:0] wait_cnt_nxt_s;
  logic [3:0]    ack_r;
  logic [3:0]    ack_nxt_s;
  logic [DW-1:0] rdata_r;
  logic [DW-1:0] rdata_nxt_s;
  logic          mem_cs_r;
  logic          mem_cs_nxt_s;
  logic [AW-1:0] mem_addr_r;
  logic [AW-1:0] mem_addr_nxt_s;
  logic          busy_r;
  logic          timeout_err_r;
  logic          timeout_err_nxt_s;

  logic [AW-1:0] addr_a_s [4];
  logic [1:0]    slot_s;
  logic [1:0]    rr_idx_s;
  logic          rr_valid_s;
  logic [1:0]    grant_idx_s;
  logic          grant_valid_s;
  logic          unused_s;

  // pixel enable, vertical count and upper hc bits do not take part in scheduling
  assign unused_s = ^{clk_pix_en, vc, hc[8:2]};

  for (genvar i = 0; i < 4; i++) begin : g_addr
    assign addr_a_s[i] = bus.addr[i*AW +: AW];
  end

  rr_pick4 u_rr_pick4 (
    .req   (bus.req),
    .ptr   (rr_ptr_r),
    .grant (rr_idx_s),
    .valid (rr_valid_s)
  );

  assign slot_s = hc[1:0];

  // winner selection: slot owner in active area, sprites first in hblank, else round-robin
  always_comb begin
    grant_idx_s   = rr_idx_s;
    grant_valid_s = rr_valid_s;
    if (!hbl && !vbl && bus.req[slot_s]) begin
      grant_idx_s   = slot_s;
      grant_valid_s = 1'b1;
    end else if (hbl && !vbl && bus.req[REQ_SPR]) begin
      grant_idx_s   = REQ_SPR;
      grant_valid_s = 1'b1;
    end else begin
      grant_idx_s   = rr_idx_s;
      grant_valid_s = rr_valid_s;
    end
  end

  // next-state and output logic; the ack cycle itself never grants so the
  // requester can update req/addr before it is considered again
  always_comb begin
    state_nxt_s       = state_r;
    owner_nxt_s       = owner_r;
    rr_ptr_nxt_s      = rr_ptr_r;
    wait_cnt_nxt_s    = wait_cnt_r;
    ack_nxt_s         = 4'b0000;
    rdata_nxt_s       = rdata_r;
    mem_cs_nxt_s      = mem_cs_r;
    mem_addr_nxt_s    = mem_addr_r;
    timeout_err_nxt_s = timeout_err_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s && (ack_r == 4'b0000)) begin
          state_nxt_s    = WAIT;
          owner_nxt_s    = grant_idx_s;
          rr_ptr_nxt_s   = grant_idx_s + 2'd1;
          wait_cnt_nxt_s = '0;
          mem_cs_nxt_s   = 1'b1;
          mem_addr_nxt_s = addr_a_s[grant_idx_s];
        end else begin
          state_nxt_s  = IDLE;
          mem_cs_nxt_s = 1'b0;
        end
      end
      WAIT: begin
        if (bus.mem_ok) begin
          state_nxt_s    = IDLE;
          rdata_nxt_s    = bus.mem_data;
          ack_nxt_s      = onehot4(owner_r);
          mem_cs_nxt_s   = 1'b0;
          wait_cnt_nxt_s = '0;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s       = IDLE;
          rdata_nxt_s       = {DW{1'b0}};
          ack_nxt_s         = onehot4(owner_r);
          mem_cs_nxt_s      = 1'b0;
          wait_cnt_nxt_s    = '0;
          timeout_err_nxt_s = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        mem_cs_nxt_s   = 1'b0;
        wait_cnt_nxt_s = '0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      owner_r       <= 2'd0;
      rr_ptr_r      <= 2'd0;
      wait_cnt_r    <= '0;
      ack_r         <= 4'b0000;
      rdata_r       <= {DW{1'b0}};
      mem_cs_r      <= 1'b0;
      mem_addr_r    <= {AW{1'b0}};
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      owner_r       <= owner_nxt_s;
      rr_ptr_r      <= rr_ptr_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      ack_r         <= ack_nxt_s;
      rdata_r       <= rdata_nxt_s;
      mem_cs_r      <= mem_cs_nxt_s;
      mem_addr_r    <= mem_addr_nxt_s;
      busy_r        <= (state_nxt_s != IDLE);
      timeout_err_r <= timeout_err_nxt_s;
    end
  end

  assign bus.ack      = ack_r;
  assign bus.rdata    = rdata_r;
  assign bus.mem_cs   = mem_cs_r;
  assign bus.mem_addr = mem_addr_r;
  assign busy         = busy_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_gfx_mem_slot_arbiter.sv
// Self-checking bench for gfx_mem_slot_arbiter: directed scenarios plus random
// transactions checked against a rule-level arbitration model.
module tb_gfx_mem_slot_arbiter;

  localparam int AW      = 22;
  localparam int DW      = 16;
  localparam int TIMEOUT = 31;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_pix_en;
  logic [8:0] hc;
  logic [8:0] vc;
  logic       hbl;
  logic       vbl;
  logic       busy;
  logic       timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int rr_ptr_m     = 0;
  bit err_m        = 1'b0;

  gfx_mem_slot_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  gfx_mem_slot_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_pix_en  (clk_pix_en),
    .hc          (hc),
    .vc          (vc),
    .hbl         (hbl),
    .vbl         (vbl),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // arbitration rules: slot owner (active), sprite priority (hblank), else first requester from pointer
  function automatic int model_pick(input logic [3:0] r, input logic [8:0] h,
                                    input logic hb, input logic vb, input int ptr);
    int s;
    s = int'(h) % 4;
    if (!hb && !vb && r[s]) return s;
    if (hb && !vb && r[3]) return 3;
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // one transaction starting at a negedge where the next posedge may grant; lat<0 means no mem_ok
  task automatic txn(input logic [3:0] r, input logic [8:0] h, input logic hb, input logic vb,
                     input int lat, input bit drop);
    int            g;
    logic [DW-1:0] d;
    logic [AW-1:0] a [4];
    for (int i = 0; i < 4; i++) a[i] = AW'($urandom);
    bus.addr = {a[3], a[2], a[1], a[0]};
    bus.req  = r;
    hc       = h;
    hbl      = hb;
    vbl      = vb;
    g        = model_pick(r, h, hb, vb, rr_ptr_m);
    if (g < 0) g = 0;
    rr_ptr_m = (g + 1) % 4;
    d        = DW'($urandom);
    @(negedge clk);
    chk("grant_cs", 64'(bus.mem_cs), 64'(1));
    chk("grant_addr", 64'(bus.mem_addr), 64'(a[g]));
    chk("grant_busy", 64'(busy), 64'(1));
    chk("grant_ack", 64'(bus.ack), 64'(0));
    hc = 9'($urandom);
    if (drop) bus.req[g] = 1'b0;
    if (lat < 0) begin
      repeat (TIMEOUT - 1) begin
        @(negedge clk);
        chk("to_wait_cs", 64'(bus.mem_cs), 64'(1));
        chk("to_wait_ack", 64'(bus.ack), 64'(0));
      end
      @(negedge clk);
      err_m = 1'b1;
      d     = '0;
    end else begin
      repeat (lat - 1) begin
        @(negedge clk);
        chk("wait_cs", 64'(bus.mem_cs), 64'(1));
        chk("wait_ack", 64'(bus.ack), 64'(0));
      end
      bus.mem_ok   = 1'b1;
      bus.mem_data = d;
      @(negedge clk);
      bus.mem_ok   = 1'b0;
      bus.mem_data = DW'($urandom);
    end
    chk("ack", 64'(bus.ack), 64'(1) << g);
    chk("rdata", 64'(bus.rdata), 64'(d));
    chk("ack_cs", 64'(bus.mem_cs), 64'(0));
    chk("ack_busy", 64'(busy), 64'(0));
    chk("terr", 64'(timeout_err), 64'(err_m));
    @(negedge clk);
    chk("post_ack", 64'(bus.ack), 64'(0));
    chk("post_cs", 64'(bus.mem_cs), 64'(0));
  endtask

  initial begin
    reset_n      = 1'b0;
    clk_pix_en   = 1'b1;
    hc           = 9'd0;
    vc           = 9'd0;
    hbl          = 1'b0;
    vbl          = 1'b0;
    bus.req      = 4'b0000;
    bus.addr     = '0;
    bus.mem_ok   = 1'b0;
    bus.mem_data = '0;

    @(negedge clk);
    chk("rst_ack", 64'(bus.ack), 64'(0));
    chk("rst_rdata", 64'(bus.rdata), 64'(0));
    chk("rst_cs", 64'(bus.mem_cs), 64'(0));
    chk("rst_addr", 64'(bus.mem_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_terr", 64'(timeout_err), 64'(0));

    // stray mem_ok while idle
    reset_n      = 1'b1;
    bus.mem_ok   = 1'b1;
    bus.mem_data = 16'hBEEF;
    @(negedge clk);
    bus.mem_ok = 1'b0;
    chk("idle_ok_ack", 64'(bus.ack), 64'(0));
    chk("idle_ok_rdata", 64'(bus.rdata), 64'(0));
    chk("idle_ok_busy", 64'(busy), 64'(0));

    // active-area slot ownership and round-robin fallback
    txn(4'b0001, 9'h040, 1'b0, 1'b0, 3, 1'b0);
    txn(4'b1001, 9'h042, 1'b0, 1'b0, 2, 1'b0);
    txn(4'b1001, 9'h042, 1'b0, 1'b0, 2, 1'b0);
    txn(4'b0011, 9'h041, 1'b0, 1'b0, 4, 1'b0);

    // hblank: sprites first, then the rest round-robin
    repeat (8) txn(4'b1111, 9'($urandom), 1'b1, 1'b0, $urandom_range(1, 4), 1'b0);
    repeat (3) txn(4'b0111, 9'($urandom), 1'b1, 1'b0, $urandom_range(1, 4), 1'b0);

    // vblank: pure round-robin at fixed latency
    repeat (5) txn(4'b1111, 9'($urandom), 1'($urandom), 1'b1, 2, 1'b0);

    // mem_ok on the last wait cycle beats the timeout
    txn(4'b0100, 9'h000, 1'b0, 1'b1, TIMEOUT, 1'b0);

    // timeout, then a normal transaction with the sticky error
    txn(4'b0010, 9'h001, 1'b0, 1'b0, -1, 1'b0);
    txn(4'b0001, 9'h000, 1'b0, 1'b0, 2, 1'b0);

    // illegal early req drop still completes
    txn(4'b1000, 9'h003, 1'b0, 1'b0, 3, 1'b1);

    // asynchronous reset in WAIT, then a late mem_ok
    bus.req = 4'b0100;
    vbl     = 1'b1;
    @(negedge clk);
    chk("pre_rst_cs", 64'(bus.mem_cs), 64'(1));
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_cs", 64'(bus.mem_cs), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_ack", 64'(bus.ack), 64'(0));
    rr_ptr_m = 0;
    err_m    = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    bus.req    = 4'b0000;
    bus.mem_ok = 1'b1;
    @(negedge clk);
    bus.mem_ok = 1'b0;
    chk("late_ok_ack", 64'(bus.ack), 64'(0));
    chk("late_ok_busy", 64'(busy), 64'(0));
    chk("late_ok_cs", 64'(bus.mem_cs), 64'(0));
    chk("late_ok_rdata", 64'(bus.rdata), 64'(0));
    chk("late_ok_terr", 64'(timeout_err), 64'(0));

    // random traffic
    for (int n = 0; n < 60; n++) begin
      txn(4'($urandom_range(1, 15)), 9'($urandom), 1'($urandom),
          1'($urandom_range(0, 3) == 0), $urandom_range(1, 6), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
